// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, start, 8 data LSB first, odd parity, stop, device ACK.
// Optional build macro PS2_TX_RETRY_EN enables automatic re-sends after NACK or watchdog timeout.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int RETRY_MAX      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  // Handshake: a byte is taken on any rising clk edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and requests while busy are dropped, not queued.

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_FRAME     = 3'd2;
  localparam logic [2:0] S_ACK       = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam logic [7:0] RETRY_LIMIT = RETRY_EN ? 8'(RETRY_MAX) : 8'd0;

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state;
  logic [IW-1:0] inh_cnt;
  logic [WW-1:0] wd_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    tx_byte;
  logic          parity;
  logic [7:0]    retry_cnt;
  logic          clk_oe_r;
  logic          data_oe_r;

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       clk_s;
  logic       data_s;
  logic       fe;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fe     = clk_prev & ~clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      bit_cnt     <= '0;
      tx_byte     <= '0;
      parity      <= 1'b0;
      retry_cnt   <= '0;
      clk_oe_r    <= 1'b0;
      data_oe_r   <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            tx_byte   <= tx_data;
            parity    <= ~^tx_data;
            ack_ok    <= 1'b0;
            retry_cnt <= '0;
            inh_cnt   <= '0;
            clk_oe_r  <= 1'b1;
            state     <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          // Start bit goes low one cycle before the clock is released.
          if (inh_cnt == IW'(INHIBIT_CYCLES - 2))
            data_oe_r <= 1'b1;
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            clk_oe_r <= 1'b0;
            bit_cnt  <= '0;
            wd_cnt   <= '0;
            state    <= S_FRAME;
          end
        end
        S_FRAME, S_ACK, S_WAIT_IDLE: begin
          if (wd_cnt == WW'(TIMEOUT_CYCLES)) begin
            data_oe_r <= 1'b0;
            if (retry_cnt != RETRY_LIMIT) begin
              retry_cnt <= retry_cnt + 1'b1;
              inh_cnt   <= '0;
              clk_oe_r  <= 1'b1;
              state     <= S_INHIBIT;
            end else begin
              err_timeout <= 1'b1;
              state       <= S_IDLE;
            end
          end else begin
            wd_cnt <= fe ? '0 : wd_cnt + 1'b1;
            case (state)
              S_FRAME: begin
                if (fe) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt < 4'd8) begin
                    data_oe_r <= ~tx_byte[bit_cnt[2:0]];
                  end else if (bit_cnt == 4'd8) begin
                    data_oe_r <= ~parity;
                  end else begin
                    data_oe_r <= 1'b0;
                    state     <= S_ACK;
                  end
                end
              end
              S_ACK: begin
                if (fe) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  ack_ok  <= ~data_s;
                  state   <= S_WAIT_IDLE;
                end
              end
              default: begin
                // Let the device finish its ACK clock before reporting or re-sending.
                if (clk_s && data_s) begin
                  if (!ack_ok && retry_cnt != RETRY_LIMIT) begin
                    retry_cnt <= retry_cnt + 1'b1;
                    inh_cnt   <= '0;
                    clk_oe_r  <= 1'b1;
                    state     <= S_INHIBIT;
                  end else begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                  end
                end
              end
            endcase
          end
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign tx_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

endmodule
